// File: rtl/itc_pkg.sv
// Shared types and constants for the intelligent traffic controller:
// the 3-bit phase encoding and the 2-bit lamp colour codes.
package itc_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000,  // highway green
        S1 = 3'b001,  // highway yellow
        S2 = 3'b010,  // all red before the country green
        S3 = 3'b011,  // country green
        S4 = 3'b100,  // country yellow
        S5 = 3'b101   // all red before the highway green
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

endpackage

// File: rtl/itc_phase_timer.sv
// Phase timer: counts cycles spent in the current phase and saturates at
// all-ones. clear_i restarts the count from zero on the next edge.
// clr resets the count asynchronously.
module itc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on phase change, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/intelligent_traffic_control.sv
// Six-phase highway/country-road controller. The highway stays green until
// the country sensor X requests service after a minimum green time. It then
// yields through yellow and all-red, and gets the green back once X drops.
// Optional feature macro: ITC_MAX_GREEN_EN caps the country green at
// MAX_CNTRY_GREEN cycles even while X is still high.
module intelligent_traffic_control
    import itc_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter int MIN_HWY_GREEN   = 4,
    parameter int YELLOW_CYCLES   = 3,
    parameter int ALLRED_CYCLES   = 1,
    parameter int MAX_CNTRY_GREEN = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] State
);

    localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_CYCLES - 1);
`ifdef ITC_MAX_GREEN_EN
    localparam logic [CNT_W-1:0] CNTRY_LAST     = CNT_W'(MAX_CNTRY_GREEN - 1);
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] t;
    logic             phase_change;

    // A change of phase restarts the timer, so t = 0 in the first cycle of
    // every phase.
    assign phase_change = (state_d != state_q);

    itc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .clr     (clr),
        .clear_i (phase_change),
        .cnt_o   (t)
    );

    // Next phase. X only matters in S0 and S3. The illegal codes fall back
    // to S0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: if (X && (t >= MIN_GREEN_LAST)) state_d = S1;
            S1: if (t == YELLOW_LAST)           state_d = S2;
            S2: if (t == ALLRED_LAST)           state_d = S3;
`ifdef ITC_MAX_GREEN_EN
            S3: if (!X || (t == CNTRY_LAST))    state_d = S4;
`else
            S3: if (!X)                         state_d = S4;
`endif
            S4: if (t == YELLOW_LAST)           state_d = S5;
            S5: if (t == ALLRED_LAST)           state_d = S0;
            default:                            state_d = S0;
        endcase
    end

    // Phase register. An asynchronous clear forces the highway green at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Lamp decode of the phase register only, so X has no path to outputs.
    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (state_q)
            S0:      hwy   = GREEN;
            S1:      hwy   = YELLOW;
            S3:      cntry = GREEN;
            S4:      cntry = YELLOW;
            default: begin
                hwy   = RED;
                cntry = RED;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_intelligent_traffic_control.sv
// Directed bench for intelligent_traffic_control. It walks the phase
// sequence cycle by cycle. It also checks async reset, the illegal-state
// recovery and, when ITC_MAX_GREEN_EN is defined, the country-green cap.
module tb_intelligent_traffic_control;

    logic       clk;
    logic       clr;
    logic       X;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] State;

    int checks   = 0;
    int failures = 0;

    intelligent_traffic_control dut (
        .clk   (clk),
        .clr   (clr),
        .X     (X),
        .hwy   (hwy),
        .cntry (cntry),
        .State (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected lamp pair for a phase, written out by hand: {hwy, cntry}.
    function automatic logic [3:0] lamps_for(input logic [2:0] s);
        case (s)
            3'd0:    return 4'b10_00;
            3'd1:    return 4'b01_00;
            3'd3:    return 4'b00_10;
            3'd4:    return 4'b00_01;
            default: return 4'b00_00;
        endcase
    endfunction

    // Apply X for n cycles. After each edge, expect phase exp_s and its lamps.
    task automatic run(input logic xv, input int n, input logic [2:0] exp_s, input string tag);
        logic [3:0] lp;
        lp = lamps_for(exp_s);
        for (int i = 0; i < n; i++) begin
            X = xv;
            @(posedge clk);
            @(negedge clk);
            check_val({tag, ".state"}, {5'd0, State}, {5'd0, exp_s});
            check_val({tag, ".hwy"},   {6'd0, hwy},   {6'd0, lp[3:2]});
            check_val({tag, ".cntry"}, {6'd0, cntry}, {6'd0, lp[1:0]});
            $display("cycle %s x=%0b state=%0d hwy=%0b cntry=%0b", tag, xv, State, hwy, cntry);
        end
    endtask

    initial begin
        clr = 1'b1;
        X   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.state", {5'd0, State}, 8'd0);
        check_val("rst.hwy",   {6'd0, hwy},   8'd2);
        check_val("rst.cntry", {6'd0, cntry}, 8'd0);
        clr = 1'b0;

        // Minimum green: X high from the first cycle after release.
        run(1'b1, 3, 3'd0, "mg.s0");
        run(1'b1, 3, 3'd1, "mg.s1");
        run(1'b1, 1, 3'd2, "mg.s2");
        run(1'b1, 1, 3'd3, "mg.s3");
`ifdef ITC_MAX_GREEN_EN
        // Country green is cut off after 8 cycles even though X stays high.
        run(1'b1, 7, 3'd3, "cap.s3");
        run(1'b1, 3, 3'd4, "cap.s4");
        run(1'b1, 1, 3'd5, "cap.s5");
        run(1'b1, 4, 3'd0, "cap.s0");
        run(1'b1, 1, 3'd1, "cap.s1");
        run(1'b0, 2, 3'd1, "cap.s1b");
        run(1'b0, 1, 3'd2, "cap.s2");
        run(1'b0, 1, 3'd3, "cap.s3b");
        run(1'b0, 3, 3'd4, "cap.s4b");
        run(1'b0, 1, 3'd5, "cap.s5b");
        run(1'b0, 1, 3'd0, "cap.s0b");
`else
        // Country hold for 12 more cycles, then release.
        run(1'b1, 12, 3'd3, "hold.s3");
        run(1'b0, 3, 3'd4, "hold.s4");
        run(1'b0, 1, 3'd5, "hold.s5");
        run(1'b0, 1, 3'd0, "hold.s0");
`endif

        // Dropped request: a single-cycle pulse after the minimum green.
        run(1'b0, 5, 3'd0, "drop.s0");
        run(1'b1, 1, 3'd1, "drop.s1a");
        run(1'b0, 2, 3'd1, "drop.s1b");
        run(1'b0, 1, 3'd2, "drop.s2");
        run(1'b0, 1, 3'd3, "drop.s3");
        run(1'b0, 3, 3'd4, "drop.s4");
        run(1'b0, 1, 3'd5, "drop.s5");
        run(1'b0, 1, 3'd0, "drop.s0b");

        // Return to country green, then reset asynchronously mid-phase.
        run(1'b1, 3, 3'd0, "ar.s0");
        run(1'b1, 3, 3'd1, "ar.s1");
        run(1'b1, 1, 3'd2, "ar.s2");
        run(1'b1, 1, 3'd3, "ar.s3");
        #2 clr = 1'b1;
        #1;
        check_val("ar.state", {5'd0, State}, 8'd0);
        check_val("ar.hwy",   {6'd0, hwy},   8'd2);
        check_val("ar.cntry", {6'd0, cntry}, 8'd0);
        @(negedge clk);
        clr = 1'b0;
        run(1'b0, 20, 3'd0, "ar.idle");

        // Illegal code 110: S0 on the next edge, with the timer restarted.
        force dut.state_q = itc_pkg::state_t'(3'b110);
        #1 release dut.state_q;
        run(1'b0, 1, 3'd0, "ill.s0");
        run(1'b1, 3, 3'd0, "ill.s0b");
        run(1'b1, 1, 3'd1, "ill.s1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intelligent_traffic_control.md
# intelligent_traffic_control

Six-phase controller for a highway/country-road intersection. The highway has priority. A single country-road vehicle sensor `X` requests a country green. The highway then yields through yellow and all-red clearance phases, and control returns to the highway once the country road is clear. The block sits between the sensor front end and the lamp drivers, and it exports its current phase for monitoring.

## Interface
Parameters:
- `CNT_W`, 8: width of the phase timer; every duration parameter must be ≤ 2^CNT_W−1.
- `MIN_HWY_GREEN`, 4: minimum number of cycles spent in S0 before a request is honoured (≥1).
- `YELLOW_CYCLES`, 3: exact number of cycles spent in S1 and in S4 (≥1).
- `ALLRED_CYCLES`, 1: exact number of cycles spent in S2 and in S5 (≥1).
- `MAX_CNTRY_GREEN`, 8: maximum number of cycles in S3 (used only with `ITC_MAX_GREEN_EN`, ≥1).

Ports:
- `clk` in 1: single clock, rising-edge.
- `clr` in 1: reset, asynchronous and active-high.
- `X` in 1: country vehicle sensor, 1 = car waiting/present; sampled synchronously.
- `hwy` out 2: highway lamp, RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
- `cntry` out 2: country lamp, same encoding.
- `State` out 3: current phase, S0=000 … S5=101.

## Operation
- Moore machine. `hwy`/`cntry` are a combinational decode of the `State` register, so lamps change in the same cycle as `State`:
  - S0: hwy GREEN, cntry RED.
  - S1: hwy YELLOW, cntry RED.
  - S2: RED/RED.
  - S3: hwy RED, cntry GREEN.
  - S4: hwy RED, cntry YELLOW.
  - S5: RED/RED.
- Phase timer `t` is cleared to 0 on every state change, otherwise increments each cycle, and saturates at all-ones.
- Transitions, evaluated at the rising clock edge:
  - S0→S1: when `X`=1 and `t` ≥ MIN_HWY_GREEN−1; otherwise stay.
  - S1→S2: when `t` = YELLOW_CYCLES−1.
  - S2→S3: when `t` = ALLRED_CYCLES−1.
  - S3→S4: when `X`=0; otherwise stay.
  - S4→S5: when `t` = YELLOW_CYCLES−1.
  - S5→S0: when `t` = ALLRED_CYCLES−1.
- `X` is ignored in S1, S2, S4 and S5. A request that drops during S1/S2 still completes the cycle through S3. S3 then lasts one cycle if `X`=0.
- Illegal encodings 110/111 go to S0 on the next edge with `t` cleared.
- Reset: `State`=S0, `t`=0, hence `hwy`=GREEN and `cntry`=RED immediately on `clr` assertion, independent of `clk`. Reset in the middle of a phase abandons that phase.
- Release: the first edge with `clr`=0 evaluates from S0 with `t`=0.

## Timing
- Latency from `X` rising in S0, with the minimum green already met, to `hwy`=YELLOW: 1 cycle.
- Highway yellow lasts exactly YELLOW_CYCLES cycles; all-red lasts exactly ALLRED_CYCLES cycles.
- Latency from `X` falling in S3 to `cntry`=YELLOW: 1 cycle.
- Complete cycle length: MIN_HWY_GREEN (at least) + 2·YELLOW_CYCLES + 2·ALLRED_CYCLES + S3 duration.
- No combinational path exists from `X` to any output.

## Configuration
- `ITC_MAX_GREEN_EN` defined: S3→S4 also occurs when `t` = MAX_CNTRY_GREEN−1, even with `X`=1.
  - If `X` is still 1 on return to S0, the next request is honoured after MIN_HWY_GREEN cycles.
- Not defined: country green holds indefinitely while `X`=1, and `MAX_CNTRY_GREEN` is unused.

## Structure
- Package `itc_pkg` holds:
  - the state enum (S0–S5, 3-bit);
  - the lamp colour constants RED/YELLOW/GREEN (2-bit).
- Sub-module `itc_phase_timer`: CNT_W saturating counter with synchronous clear on state change and asynchronous reset on `clr`.
- The top level holds the state register, next-state logic and the lamp decode.

## Test plan
- Reset: assert `clr` mid-S3 with no clock edge → `State`=000, `hwy`=10, `cntry`=00 immediately; still S0 after release with `X`=0 for 20 cycles.
- Minimum green: `X`=1 from the first cycle after reset → S1 entered on the 4th edge; `hwy`=01 for exactly 3 cycles, then S2 for 1 cycle, then S3 with `cntry`=10.
- Country hold/release: `X`=1 for 12 cycles in S3, then 0 → S4 one cycle later; 3 cycles in S4, 1 in S5, then S0.
- Dropped request: `X` pulses high for 1 cycle in S0 after the minimum green, then stays 0 → the cycle still runs S1(3), S2(1), S3(1), S4(3), S5(1), S0.
- `ITC_MAX_GREEN_EN`: `X` held 1 → S3 lasts exactly 8 cycles; S0 is re-entered, then S1 follows after 4 cycles.
- Illegal state: force `State`=110 → S0 on the next edge with lamps GREEN/RED.
